bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 Parameter ERR_CNT_W, default 8: width of the invalid-code error counter.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 Port in_valid, input, 1: bcd_in is sampled on this cycle when high.
REQ-005 Port bcd_in, input, 4: one BCD digit, legal codes 0-9.
REQ-006 Port binary_out, output, 3: registered binary value of the last sampled digit.
REQ-007 Port out_valid, output, 1: one-cycle pulse, binary_out and flags updated this cycle.
REQ-008 Port sat, output, 1: last sampled digit was 8 or 9 and was clamped.
REQ-009 Port err, output, 1: last sampled code was not BCD (10-15).
REQ-010 Port err_cnt, output, ERR_CNT_W: count of invalid codes sampled since reset.

Function
REQ-011 On a clk edge with in_valid=1, the block SHALL register binary_out, sat and err from bcd_in; latency is exactly 1 cycle.
REQ-012 Codes 0-7 SHALL map to binary_out = bcd_in[2:0], with sat=0 and err=0.
REQ-013 Codes 8 and 9 SHALL saturate binary_out to 3'b111, with sat=1 and err=0.
REQ-014 Codes 10-15 SHALL force binary_out to 3'b000, with err=1 and sat=0.
REQ-015 sat and err SHALL never be high together.
REQ-016 out_valid SHALL be in_valid delayed by one cycle; back-to-back in_valid SHALL give a result every cycle.
REQ-017 With in_valid=0, binary_out, sat and err SHALL hold their last values and out_valid SHALL be 0.
REQ-018 err_cnt SHALL increment by 1 on each sampled invalid code, update in the same cycle as err, and saturate at all-ones with no wrap.
REQ-019 bcd_in SHALL be ignored, and SHALL not affect any output, while in_valid=0.

Reset
REQ-020 Asserting rst_n=0 SHALL immediately clear binary_out, sat, err, out_valid and err_cnt to 0, regardless of clk.
REQ-021 A sample pending at reset assertion SHALL be discarded.
REQ-022 The first sample SHALL be taken on the first rising edge after rst_n deasserts with in_valid=1.

Structure
REQ-023 A shared package bcd_pkg SHALL hold BCD_MAX=9, BIN_W=3, BIN_SAT=3'b111 and the digit-class enum {DIG_OK, DIG_SAT, DIG_ERR}.
REQ-024 One combinational sub-module, bcd_digit_decode, SHALL map a 4-bit code to a 3-bit value plus a digit class.
REQ-025 The top level SHALL contain only the registers, the valid pipeline and the error counter.

Verification
REQ-026 Reset: hold rst_n=0 mid-cycle -> all outputs 0 at once, before any clk edge.
REQ-027 Legal digit: in_valid=1, bcd_in=4'b0001 -> next cycle binary_out=3'b001, out_valid=1, sat=0, err=0.
REQ-028 Invalid code: in_valid=1, bcd_in=4'b1010 -> next cycle binary_out=3'b000, err=1, err_cnt=1.
REQ-029 Saturation: bcd_in=9 then 8 back-to-back -> binary_out=3'b111 with sat=1 on two consecutive cycles.
REQ-030 Hold: after a sample of 5, drive in_valid=0 with bcd_in=12 -> binary_out stays 3'b101, out_valid=0, err_cnt unchanged.
REQ-031 Counter saturation: drive 2^ERR_CNT_W+3 invalid samples -> err_cnt stops at all-ones.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and digit classes for BCD-to-binary conversion
package bcd_pkg;
  localparam int BCD_MAX = 9;
  localparam int BIN_W = 3;
  localparam logic [BIN_W-1:0] BIN_SAT = 3'b111;
  typedef enum logic [1:0] {DIG_OK, DIG_SAT, DIG_ERR} dig_class_e;
endpackage

// File: rtl/bcd_digit_decode.sv
// bcd_digit_decode: maps one 4-bit code to a clamped 3-bit value and its digit class
module bcd_digit_decode
  import bcd_pkg::*;
(
  input  logic [3:0]       code,
  output logic [BIN_W-1:0] value,
  output dig_class_e       cls
);
  always_comb begin
    cls = code > 4'(BCD_MAX) ? DIG_ERR : code[3] ? DIG_SAT : DIG_OK;
    value = cls == DIG_ERR ? '0 : cls == DIG_SAT ? BIN_SAT : code[BIN_W-1:0];
  end
endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: registered BCD digit to 3-bit binary with saturation, error flag and error count
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [3:0]           bcd_in,
  output logic [BIN_W-1:0]     binary_out,
  output logic                 out_valid,
  output logic                 sat,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  logic [BIN_W-1:0] dec_value;
  dig_class_e dec_cls;
  bcd_digit_decode u_decode (
    .code  (bcd_in),
    .value (dec_value),
    .cls   (dec_cls)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary_out <= '0;
      out_valid <= 1'b0;
      sat <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        binary_out <= dec_value;
        sat <= dec_cls == DIG_SAT;
        err <= dec_cls == DIG_ERR;
        if (dec_cls == DIG_ERR && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed self-checking bench for bcd_to_binary
module tb_bcd_to_binary;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] bcd_in = 4'd0;
  logic [2:0] binary_out;
  logic out_valid, sat, err;
  logic [7:0] err_cnt;
  int tests = 0;
  int fails = 0;
  logic [13:0] got, exp;
  logic [2:0] legal_exp [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};

  bcd_to_binary #(.ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .bcd_in     (bcd_in),
    .binary_out (binary_out),
    .out_valid  (out_valid),
    .sat        (sat),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // got/exp layout: {binary_out, sat, err, out_valid, err_cnt}
  task automatic step(input logic v, input logic [3:0] d);
    in_valid = v;
    bcd_in = d;
    @(posedge clk);
    #1;
    got = {binary_out, sat, err, out_valid, err_cnt};
  endtask

  task automatic test_reset;
    #2;
    got = {binary_out, sat, err, out_valid, err_cnt};
    tests++;
    if (got !== 14'd0) begin
      fails++;
      $display("FAIL reset_initial: got %b required %b", got, 14'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_legal;
    for (int d = 0; d < 10; d++) begin
      step(1'b1, 4'(d));
      exp = {legal_exp[d], d >= 8, 1'b0, 1'b1, 8'd0};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL legal_%0d: got %b required %b", d, got, exp);
      end
    end
  endtask

  task automatic test_invalid;
    for (int d = 10; d < 16; d++) begin
      step(1'b1, 4'(d));
      exp = {3'b000, 1'b0, 1'b1, 1'b1, 8'(d - 9)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL invalid_%0d: got %b required %b", d, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 4'd9);
    exp = {3'b111, 1'b1, 1'b0, 1'b1, 8'd6};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL b2b_sat_9: got %b required %b", got, exp);
    end
    step(1'b1, 4'd8);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL b2b_sat_8: got %b required %b", got, exp);
    end
    step(1'b1, 4'd1);
    exp = {3'b001, 1'b0, 1'b0, 1'b1, 8'd6};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL b2b_after_sat_1: got %b required %b", got, exp);
    end
  endtask

  task automatic test_hold;
    step(1'b1, 4'd5);
    exp = {3'b101, 1'b0, 1'b0, 1'b1, 8'd6};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL hold_sample_5: got %b required %b", got, exp);
    end
    exp = {3'b101, 1'b0, 1'b0, 1'b0, 8'd6};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd12);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL hold_cycle_%0d: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    #3;
    in_valid = 1'b1;
    bcd_in = 4'd3;
    rst_n = 1'b0;
    #1;
    got = {binary_out, sat, err, out_valid, err_cnt};
    tests++;
    if (got !== 14'd0) begin
      fails++;
      $display("FAIL reset_async: got %b required %b", got, 14'd0);
    end
    @(posedge clk);
    #1;
    got = {binary_out, sat, err, out_valid, err_cnt};
    tests++;
    if (got !== 14'd0) begin
      fails++;
      $display("FAIL reset_pending_discard: got %b required %b", got, 14'd0);
    end
    rst_n = 1'b1;
    step(1'b1, 4'd3);
    exp = {3'b011, 1'b0, 1'b0, 1'b1, 8'd0};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL reset_first_sample: got %b required %b", got, exp);
    end
  endtask

  task automatic test_cnt_sat;
    for (int i = 1; i <= 259; i++) begin
      step(1'b1, 4'(10 + (i % 6)));
      tests++;
      if (sat && err) begin
        fails++;
        $display("FAIL sat_err_exclusive_%0d: sat %b err %b required not both", i, sat, err);
      end
      if (i == 254 || i == 255 || i == 259) begin
        exp = {3'b000, 1'b0, 1'b1, 1'b1, (i < 255) ? 8'(i) : 8'hff};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL cnt_sat_%0d: got %b required %b", i, got, exp);
        end
      end
    end
    step(1'b1, 4'd2);
    exp = {3'b010, 1'b0, 1'b0, 1'b1, 8'hff};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL cnt_sat_then_legal: got %b required %b", got, exp);
    end
    step(1'b0, 4'd0);
  endtask

  initial begin
    test_reset;
    test_legal;
    test_invalid;
    test_back_to_back;
    test_hold;
    test_reset_mid;
    test_cnt_sat;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
